// File: rtl/control_unit.sv
// Sequencing controller for the 8-bit single-cycle datapath: combinational decode
// gated by a run-state FSM, shadow call-stack depth tracking and a retired counter.
module control_unit #(
  parameter int STACK_DEPTH = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       opcodeFunc,
  input  logic             Cout,
  input  logic             Zout,
  input  logic             halt,
  output logic             pcEn,
  output logic             push,
  output logic             pop,
  output logic             memWriteEn,
  output logic             regWriteEn,
  output logic             immAndmem,
  output logic             stm,
  output logic             ldm,
  output logic             branch,
  output logic             jmp,
  output logic             ret,
  output logic             cWriteEn,
  output logic             zWriteEn,
  output logic [3:0]       aluOp,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       stackDepth
);

  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, HALTED = 2'b10, FAULT = 2'b11} state_t;

  typedef struct packed {
    logic       push, pop, memWriteEn, regWriteEn, immAndmem, stm, ldm;
    logic       branch, jmp, ret, cWriteEn, zWriteEn;
    logic [3:0] aluOp;
  } ctrl_t;

  state_t st;
  ctrl_t  dec, ctrl;
  logic   active, isJsb, isRet, overflow, underflow, fault;

  assign state = st;

  always_comb begin
    dec = '0;
    unique case (opcodeFunc[4:3])
      2'b00, 2'b01: begin
        dec.aluOp      = {1'b0, opcodeFunc[2:0]};
        dec.regWriteEn = 1'b1;
        dec.cWriteEn   = 1'b1;
        dec.zWriteEn   = 1'b1;
        dec.immAndmem  = opcodeFunc[3];
      end
      2'b10: begin
        case (opcodeFunc[2:0])
          3'b000: begin dec.immAndmem = 1'b1; dec.ldm = 1'b1; dec.regWriteEn = 1'b1; end
          3'b001: begin dec.immAndmem = 1'b1; dec.stm = 1'b1; dec.memWriteEn = 1'b1; end
          3'b010: begin
            dec.aluOp      = 4'b1000;
            dec.regWriteEn = 1'b1;
            dec.cWriteEn   = 1'b1;
            dec.zWriteEn   = 1'b1;
          end
          3'b100:  dec.branch = Zout;
          3'b101:  dec.branch = ~Zout;
          3'b110:  dec.branch = Cout;
          3'b111:  dec.branch = ~Cout;
          default: ;
        endcase
      end
      default: begin
        case (opcodeFunc[2:0])
          3'b000:  dec.jmp = 1'b1;
          3'b001:  begin dec.jmp = 1'b1; dec.push = 1'b1; end
          3'b010:  begin dec.ret = 1'b1; dec.pop = 1'b1; end
          default: ;
        endcase
      end
    endcase
  end

  // halt takes priority over everything, including stack faults
  assign active    = (st == RUN) && !halt;
  assign isJsb     = (opcodeFunc == 5'b11001);
  assign isRet     = (opcodeFunc == 5'b11010);
  assign overflow  = isJsb && (stackDepth == 4'(STACK_DEPTH));
  assign underflow = isRet && (stackDepth == 4'd0);
  assign fault     = active && (overflow || underflow);
  assign pcEn      = active && !fault;

  always_comb begin
    ctrl = '0;
    if (pcEn) ctrl = dec;
  end

  assign push       = ctrl.push;
  assign pop        = ctrl.pop;
  assign memWriteEn = ctrl.memWriteEn;
  assign regWriteEn = ctrl.regWriteEn;
  assign immAndmem  = ctrl.immAndmem;
  assign stm        = ctrl.stm;
  assign ldm        = ctrl.ldm;
  assign branch     = ctrl.branch;
  assign jmp        = ctrl.jmp;
  assign ret        = ctrl.ret;
  assign cWriteEn   = ctrl.cWriteEn;
  assign zWriteEn   = ctrl.zWriteEn;
  assign aluOp      = ctrl.aluOp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= IDLE;
      retired    <= '0;
      stackDepth <= '0;
    end else begin
      case (st)
        IDLE: if (start) st <= RUN;
        RUN: begin
          if (halt)       st <= HALTED;
          else if (fault) st <= FAULT;
          if (pcEn) begin
            retired <= retired + CNT_W'(1);
            if (isJsb)      stackDepth <= stackDepth + 4'd1;
            else if (isRet) stackDepth <= stackDepth - 4'd1;
          end
        end
        default: st <= st;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Randomized bench for control_unit against a spec-level model of run state,
// call depth and retired count; directed cases cover the stack and halt corners.
module tb_control_unit;
  localparam int STACK_DEPTH = 8;
  localparam int CNT_W       = 16;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0, Cout = 1'b0, Zout = 1'b0, halt = 1'b0;
  logic [4:0] opcodeFunc = '0;
  logic pcEn, push, pop, memWriteEn, regWriteEn, immAndmem, stm, ldm;
  logic branch, jmp, ret, cWriteEn, zWriteEn;
  logic [3:0] aluOp, stackDepth;
  logic [1:0] state;
  logic [CNT_W-1:0] retired;

  int tests = 0, fails = 0;
  int mState = 0, mDepth = 0, mRetired = 0;

  control_unit #(.STACK_DEPTH(STACK_DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .opcodeFunc(opcodeFunc), .Cout(Cout), .Zout(Zout),
    .halt(halt), .pcEn(pcEn), .push(push), .pop(pop), .memWriteEn(memWriteEn),
    .regWriteEn(regWriteEn), .immAndmem(immAndmem), .stm(stm), .ldm(ldm), .branch(branch),
    .jmp(jmp), .ret(ret), .cWriteEn(cWriteEn), .zWriteEn(zWriteEn), .aluOp(aluOp),
    .state(state), .retired(retired), .stackDepth(stackDepth)
  );

  always #5 clk = ~clk;

  wire [16:0] outVec = {pcEn, push, pop, memWriteEn, regWriteEn, immAndmem, stm, ldm,
                        branch, jmp, ret, cWriteEn, zWriteEn, aluOp};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected control vector from the decode table; state 1 is RUN.
  function automatic logic [16:0] expOut(int st, int op, bit c, bit z, bit h, int d);
    bit pe = 0, pu = 0, po = 0, mw = 0, rw = 0, im = 0, sm = 0, lm = 0;
    bit br = 0, jp = 0, rt = 0, cw = 0, zw = 0;
    int alu = 0;
    if (st != 1 || h) return '0;
    if (op == 25 && d == STACK_DEPTH) return '0;
    if (op == 26 && d == 0) return '0;
    pe = 1;
    if (op < 16) begin
      alu = op % 8; rw = 1; cw = 1; zw = 1; im = (op >= 8);
    end else begin
      case (op)
        16: begin im = 1; lm = 1; rw = 1; end
        17: begin im = 1; sm = 1; mw = 1; end
        18: begin alu = 8; rw = 1; cw = 1; zw = 1; end
        20: br = z;
        21: br = !z;
        22: br = c;
        23: br = !c;
        24: jp = 1;
        25: begin jp = 1; pu = 1; end
        26: begin rt = 1; po = 1; end
        default: ;
      endcase
    end
    return {pe, pu, po, mw, rw, im, sm, lm, br, jp, rt, cw, zw, 4'(alu)};
  endfunction

  task automatic step(input bit s, input int op, input bit c, input bit z, input bit h);
    logic [16:0] e;
    @(negedge clk);
    start = s; opcodeFunc = 5'(op); Cout = c; Zout = z; halt = h;
    #1;
    e = expOut(mState, op, c, z, h, mDepth);
    check("ctrl", 32'(outVec), 32'(e));
    @(posedge clk);
    case (mState)
      0: if (s) mState = 1;
      1: begin
        if (h) mState = 2;
        else if (!e[16]) mState = 3;
        else begin
          mRetired = (mRetired + 1) % (1 << CNT_W);
          if (op == 25) mDepth++;
          if (op == 26) mDepth--;
        end
      end
      default: ;
    endcase
    #1;
    check("state", 32'(state), 32'(mState));
    check("retired", 32'(retired), 32'(mRetired));
    check("depth", 32'(stackDepth), 32'(mDepth));
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1; start = 0; halt = 0; opcodeFunc = 5'd0;
    mState = 0; mDepth = 0; mRetired = 0;
    #1;
    check("rstState", 32'(state), 0);
    check("rstCtrl", 32'(outVec), 0);
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    doReset();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    check("idleRetired", 32'(retired), 0);
    step(1, 2, 0, 0, 0);                    // IDLE -> RUN
    step(0, 2, 0, 0, 0);                    // SUB
    check("subRetired", 32'(retired), 1);
    step(0, 20, 0, 1, 0);
    step(0, 20, 0, 0, 0);
    step(0, 23, 0, 0, 0);
    step(0, 9, 1, 1, 0);
    step(0, 16, 0, 0, 0);
    step(0, 17, 0, 0, 0);
    step(0, 18, 0, 0, 0);

    // overflow: 8 calls fill the stack, the 9th faults
    doReset();
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < STACK_DEPTH; i++) step(0, 25, 0, 0, 0);
    check("fullDepth", 32'(stackDepth), 8);
    step(0, 25, 0, 0, 0);
    check("ovfState", 32'(state), 3);
    check("ovfRetired", 32'(retired), 8);
    step(1, 2, 0, 0, 0);

    // underflow from a fresh run
    doReset();
    step(1, 0, 0, 0, 0);
    step(0, 26, 0, 0, 0);
    check("unfState", 32'(state), 3);

    doReset();
    step(1, 0, 0, 0, 0);
    step(0, 25, 0, 0, 0);
    check("jsbDepth", 32'(stackDepth), 1);
    step(0, 26, 0, 0, 0);
    check("retDepth", 32'(stackDepth), 0);
    check("retState", 32'(state), 1);

    // halt beats a call, then sticks
    step(0, 25, 0, 0, 1);
    check("haltState", 32'(state), 2);
    step(1, 0, 0, 0, 0);
    step(1, 25, 0, 0, 0);

    // async reset mid-cycle
    doReset();
    step(1, 0, 0, 0, 0);
    step(0, 3, 0, 0, 0);
    @(negedge clk);
    opcodeFunc = 5'd0;
    #2 rst = 1;
    #1;
    check("asyncState", 32'(state), 0);
    check("asyncCtrl", 32'(outVec), 0);
    check("asyncRetired", 32'(retired), 0);
    mState = 0; mDepth = 0; mRetired = 0;
    @(negedge clk);
    rst = 0;

    // random episodes
    for (int ep = 0; ep < 20; ep++) begin
      doReset();
      for (int n = 0; n < 60; n++) begin
        int op, r;
        r = $urandom_range(0, 99);
        if (r < 20)      op = 25;
        else if (r < 40) op = 26;
        else             op = $urandom_range(0, 31);
        step(bit'($urandom_range(0, 1)), op, bit'($urandom_range(0, 1)),
             bit'($urandom_range(0, 1)), ($urandom_range(0, 99) < 2));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
